// File: rtl/osd_ctm_mriscv_tracegen_if.sv
// Trace event type and the retire/trace bundle shared by the trace generator and its environment.
package osd_ctm_mriscv_tracegen_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] insn;
    logic [31:0] wbdata;
    logic        wben;
    logic [4:0]  wbreg;
    logic        jb;
    logic        jal;
    logic        jr;
    logic [31:0] jbtarget;
    logic        valid_ras;
    logic        valid_csr;
    logic [11:0] csr;
    logic [31:0] csr_value;
    logic        xcpt;
  } mriscv_trace_exec;
endpackage

interface osd_ctm_mriscv_tracegen_if #(parameter int CNT_WIDTH = 16);
  import osd_ctm_mriscv_tracegen_pkg::*;

  logic                 trace_enable;
  logic                 retire_valid;
  logic [31:0]          retire_pc;
  logic [31:0]          retire_insn;
  logic                 retire_xcpt;
  mriscv_trace_exec     trace_port;
  logic [CNT_WIDTH-1:0] event_count;
  logic [CNT_WIDTH-1:0] drop_count;

  modport master (
    output trace_enable, retire_valid, retire_pc, retire_insn, retire_xcpt,
    input  trace_port, event_count, drop_count
  );

  modport slave (
    input  trace_enable, retire_valid, retire_pc, retire_insn, retire_xcpt,
    output trace_port, event_count, drop_count
  );
endinterface

// File: rtl/osd_ctm_mriscv_tracegen.sv
// Pairs each retired JAL/JALR with the PC of the next retired instruction and emits one trace event per jump.
// Optional macro OSD_CTM_MRISCV_CALLRET_FILTER_EN restricts tracing to calls and returns.
module osd_ctm_mriscv_tracegen
  import osd_ctm_mriscv_tracegen_pkg::*;
#(
  parameter int MAX_WAIT  = 256,
  parameter int CNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  osd_ctm_mriscv_tracegen_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [31:0]          r_jpc, w_jpc_nxt;
  logic                 r_jal, w_jal_nxt;
  logic                 r_jr, w_jr_nxt;
  logic [WAIT_W-1:0]    r_wait, w_wait_nxt;
  mriscv_trace_exec     r_trace;
  logic [CNT_WIDTH-1:0] r_event_count;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic                 w_emit, w_drop;

  logic w_is_jal, w_is_jalr, w_qualifies, w_is_jump;

  assign w_is_jal  = (bus.retire_insn[6:0] == 7'b1101111);
  assign w_is_jalr = (bus.retire_insn[6:0] == 7'b1100111) && (bus.retire_insn[14:12] == 3'b000);

`ifdef OSD_CTM_MRISCV_CALLRET_FILTER_EN
  logic w_rd_link, w_rs1_link;
  assign w_rd_link   = (bus.retire_insn[11:7] == 5'd1) || (bus.retire_insn[11:7] == 5'd5);
  assign w_rs1_link  = (bus.retire_insn[19:15] == 5'd1) || (bus.retire_insn[19:15] == 5'd5);
  // Calls link through ra/t0; returns jump through ra/t0 without linking.
  assign w_qualifies = ((w_is_jal || w_is_jalr) && w_rd_link) ||
                       (w_is_jalr && (bus.retire_insn[11:7] == 5'd0) && w_rs1_link);
`else
  assign w_qualifies = w_is_jal || w_is_jalr;
`endif

  assign w_is_jump = w_qualifies && bus.retire_valid && !bus.retire_xcpt && bus.trace_enable;

  always_comb begin
    w_state_nxt = r_state;
    w_jpc_nxt   = r_jpc;
    w_jal_nxt   = r_jal;
    w_jr_nxt    = r_jr;
    w_wait_nxt  = r_wait;
    w_emit      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_jump) begin
          w_jpc_nxt   = bus.retire_pc;
          w_jal_nxt   = w_is_jal;
          w_jr_nxt    = w_is_jalr;
          w_wait_nxt  = {WAIT_W{1'b0}};
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!bus.trace_enable) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = {WAIT_W{1'b0}};
        end else if (bus.retire_valid) begin
          // An excepting target still has a valid PC, so it completes the pending jump.
          w_emit     = 1'b1;
          w_wait_nxt = {WAIT_W{1'b0}};
          if (w_is_jump) begin
            w_jpc_nxt   = bus.retire_pc;
            w_jal_nxt   = w_is_jal;
            w_jr_nxt    = w_is_jalr;
            w_state_nxt = ST_PEND;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_drop      = 1'b1;
          w_wait_nxt  = {WAIT_W{1'b0}};
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_nxt = r_wait + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, capture registers, registered trace event and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_jpc         <= 32'h0;
      r_jal         <= 1'b0;
      r_jr          <= 1'b0;
      r_wait        <= {WAIT_W{1'b0}};
      r_trace       <= '0;
      r_event_count <= {CNT_WIDTH{1'b0}};
      r_drop_count  <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_jpc   <= w_jpc_nxt;
      r_jal   <= w_jal_nxt;
      r_jr    <= w_jr_nxt;
      r_wait  <= w_wait_nxt;
      r_trace <= '0;
      if (w_emit) begin
        r_trace.valid    <= 1'b1;
        r_trace.pc       <= r_jpc;
        r_trace.jbtarget <= bus.retire_pc;
        r_trace.jal      <= r_jal;
        r_trace.jr       <= r_jr;
        r_event_count    <= r_event_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
        r_drop_count <= r_drop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.trace_port  = r_trace;
  assign bus.event_count = r_event_count;
  assign bus.drop_count  = r_drop_count;

endmodule

// File: tb/tb_osd_ctm_mriscv_tracegen.sv
// Directed bench for osd_ctm_mriscv_tracegen with MAX_WAIT=4 and 4-bit counters so wrap/saturation are reachable.
module tb_osd_ctm_mriscv_tracegen;
  import osd_ctm_mriscv_tracegen_pkg::*;

  localparam int MW = 4;
  localparam int CW = 4;
  localparam logic [31:0] JAL_X0_8 = 32'h0080006F;
  localparam logic [31:0] RET      = 32'h00008067;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] JAL_X0   = 32'h0000006F;
  localparam logic [31:0] JAL_RA   = 32'h000000EF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  osd_ctm_mriscv_tracegen_if #(.CNT_WIDTH(CW)) bus ();

  osd_ctm_mriscv_tracegen #(.MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic xcpt);
    bus.retire_valid = 1'b1;
    bus.retire_pc    = pc;
    bus.retire_insn  = insn;
    bus.retire_xcpt  = xcpt;
    step();
    bus.retire_valid = 1'b0;
    bus.retire_xcpt  = 1'b0;
    bus.retire_insn  = NOP;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic expect_event(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic jal, input logic jr);
    check_val({tag, ".valid"}, 64'(bus.trace_port.valid), 64'd1);
    check_val({tag, ".pc"}, 64'(bus.trace_port.pc), 64'(pc));
    check_val({tag, ".jbtarget"}, 64'(bus.trace_port.jbtarget), 64'(tgt));
    check_val({tag, ".jal"}, 64'(bus.trace_port.jal), 64'(jal));
    check_val({tag, ".jr"}, 64'(bus.trace_port.jr), 64'(jr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.trace_enable = 1'b1;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = 32'h0;
    bus.retire_insn  = NOP;
    bus.retire_xcpt  = 1'b0;
    do_reset();
    check_val("rst_trace", 64'(bus.trace_port), 64'd0);
    check_val("rst_event", 64'(bus.event_count), 64'd0);
    check_val("rst_drop", 64'(bus.drop_count), 64'd0);

    // Basic JAL: target retires two cycles after the jump.
    retire(32'h100, JAL_X0_8, 1'b0);
    check_val("basic_wait0", 64'(bus.trace_port.valid), 64'd0);
    idle(1);
    check_val("basic_wait1", 64'(bus.trace_port.valid), 64'd0);
    retire(32'h180, NOP, 1'b0);
    expect_event("basic", 32'h100, 32'h180, 1'b1, 1'b0);
    check_val("basic_event", 64'(bus.event_count), 64'd1);
    idle(1);
    check_val("basic_pulse_end", 64'(bus.trace_port), 64'd0);

    // Chained jumps.
    retire(32'h200, RET, 1'b0);
    retire(32'h400, JAL_X0_8, 1'b0);
    expect_event("chain0", 32'h200, 32'h400, 1'b0, 1'b1);
    retire(32'h500, NOP, 1'b0);
    expect_event("chain1", 32'h400, 32'h500, 1'b1, 1'b0);
    check_val("chain_event", 64'(bus.event_count), 64'd3);

    // Timeout: four idle cycles drop the jump.
    retire(32'h100, JAL_X0_8, 1'b0);
    idle(3);
    check_val("to_nodrop_yet", 64'(bus.drop_count), 64'd0);
    idle(1);
    check_val("to_drop", 64'(bus.drop_count), 64'd1);
    check_val("to_novalid", 64'(bus.trace_port.valid), 64'd0);
    retire(32'h300, NOP, 1'b0);
    check_val("to_idle", 64'(bus.trace_port.valid), 64'd0);
    // Retire on the fourth cycle wins over the drop.
    retire(32'h100, JAL_X0_8, 1'b0);
    idle(3);
    retire(32'h140, NOP, 1'b0);
    expect_event("to_edge", 32'h100, 32'h140, 1'b1, 1'b0);
    check_val("to_edge_drop", 64'(bus.drop_count), 64'd1);
    check_val("to_edge_event", 64'(bus.event_count), 64'd4);

    // Excepting jump is not captured.
    retire(32'h600, JAL_X0_8, 1'b1);
    retire(32'h610, NOP, 1'b0);
    check_val("xcpt_novalid", 64'(bus.trace_port.valid), 64'd0);

    // Disable while pending beats a simultaneous retire.
    retire(32'h700, JAL_X0_8, 1'b0);
    bus.trace_enable = 1'b0;
    retire(32'h710, NOP, 1'b0);
    bus.trace_enable = 1'b1;
    check_val("dis_novalid", 64'(bus.trace_port.valid), 64'd0);
    retire(32'h720, NOP, 1'b0);
    check_val("dis_idle", 64'(bus.trace_port.valid), 64'd0);
    check_val("dis_event", 64'(bus.event_count), 64'd4);
    check_val("dis_drop", 64'(bus.drop_count), 64'd1);

    // Reset while pending.
    retire(32'h800, JAL_X0_8, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstp_trace", 64'(bus.trace_port), 64'd0);
    check_val("rstp_event", 64'(bus.event_count), 64'd0);
    check_val("rstp_drop", 64'(bus.drop_count), 64'd0);
    retire(32'h810, NOP, 1'b0);
    check_val("rstp_noemit", 64'(bus.trace_port.valid), 64'd0);

    // Call/return filter.
    retire(32'h10, JAL_X0, 1'b0);
    retire(32'h20, NOP, 1'b0);
`ifdef OSD_CTM_MRISCV_CALLRET_FILTER_EN
    check_val("filt_plain", 64'(bus.trace_port.valid), 64'd0);
`else
    expect_event("filt_plain", 32'h10, 32'h20, 1'b1, 1'b0);
`endif
    retire(32'h10, JAL_RA, 1'b0);
    retire(32'h20, NOP, 1'b0);
    expect_event("filt_call", 32'h10, 32'h20, 1'b1, 1'b0);
`ifdef OSD_CTM_MRISCV_CALLRET_FILTER_EN
    check_val("filt_event", 64'(bus.event_count), 64'd1);
`else
    check_val("filt_event", 64'(bus.event_count), 64'd2);
`endif

    // Event counter wraps after 2^CW events (uses JAL ra so the filter build also counts).
    do_reset();
    retire(32'h1000, JAL_RA, 1'b0);
    for (int i = 1; i < 16; i++) retire(32'h1000 + 32'(i) * 32'h10, JAL_RA, 1'b0);
    check_val("wrap_15", 64'(bus.event_count), 64'd15);
    retire(32'h2000, NOP, 1'b0);
    expect_event("wrap_last", 32'h10F0, 32'h2000, 1'b1, 1'b0);
    check_val("wrap_0", 64'(bus.event_count), 64'd0);

    // Drop counter saturates.
    for (int i = 0; i < 17; i++) begin
      retire(32'h3000, JAL_RA, 1'b0);
      idle(MW);
      if (i == 14) check_val("sat_15", 64'(bus.drop_count), 64'd15);
    end
    check_val("sat_hold", 64'(bus.drop_count), 64'd15);
    check_val("sat_event", 64'(bus.event_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
